// File: rtl/button_request_queue.sv
// button_request_queue
//   Upstream stage for the LED walker. Synchronises and debounces a raw
//   push-button and counts queued presses. It then issues one walk request
//   per press. Each request is held until the walker reports busy. The next
//   request waits until the walker has gone idle again, because the walker
//   samples its request only on its slow strobe and ignores it while busy.
//
// Ports
//   i_clk       system clock, all state on the rising edge
//   i_reset_n   asynchronous active-low reset
//   i_btn       raw push-button, asynchronous, active-high
//   i_busy      walker busy flag
//   o_request   registered walk request
//   o_pending   queued presses not yet issued
//   o_overflow  sticky: a press was dropped because the queue was full
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | no request outstanding; take a queued press when not busy
// REQ       | o_request held high until the walker reports busy
// WAIT_DONE | walk in progress; wait for busy to drop

module button_request_queue #(
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int LGDEPTH         = 3
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic               i_btn,
   input  logic               i_busy,
   output logic               o_request,
   output logic [LGDEPTH-1:0] o_pending,
   output logic               o_overflow
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0]      DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [LGDEPTH-1:0] PEND_MAX = '1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE} state_t;

   logic               r_sync1, r_sync2;
   logic               r_db, r_db_prev;
   logic [CW-1:0]      r_db_cnt;
   logic               r_press;
   logic [LGDEPTH-1:0] r_pending;
   logic               r_overflow;
   logic               r_request;
   state_t             r_state;
   state_t             w_state_next;
   logic               w_take;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
      end
   end

   // The counter only runs while the synced level disagrees with the
   // debounced level. It clears on the flip, so it tops out at DB_LAST
   // and never wraps.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_db     <= 1'b0;
         r_db_cnt <= '0;
      end else if (r_sync2 == r_db) begin
         r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
         r_db     <= r_sync2;
         r_db_cnt <= '0;
      end else begin
         r_db_cnt <= r_db_cnt + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_db_prev <= 1'b0;
         r_press   <= 1'b0;
      end else begin
         r_db_prev <= r_db;
         r_press   <= r_db & ~r_db_prev;
      end
   end

   // A simultaneous press and take cancel out, so a full queue loses nothing.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_pending  <= '0;
         r_overflow <= 1'b0;
      end else if (r_press && !w_take) begin
         if (r_pending == PEND_MAX) begin
            r_overflow <= 1'b1;
         end else begin
            r_pending <= r_pending + 1'b1;
         end
      end else if (w_take && !r_press) begin
         r_pending <= r_pending - 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state   <= IDLE;
         r_request <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_request <= (w_state_next == REQ);
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_take       = 1'b0;
      case (r_state)
         IDLE: begin
            if ((r_pending != '0) && !i_busy) begin
               w_state_next = REQ;
               w_take       = 1'b1;
            end
         end
         REQ: begin
            if (i_busy) begin
               w_state_next = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (!i_busy) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign o_request  = r_request;
   assign o_pending  = r_pending;
   assign o_overflow = r_overflow;

endmodule

// File: doc/button_request_queue.md
Name: button_request_queue

Overview:
- Upstream stage for the LED walker: turns a raw, bouncy push-button into clean walk requests.
- Synchronises and debounces the button, counts queued presses, and issues one request per press.
- Holds each request until the walker reports busy, then waits for the walker to go idle before issuing the next.
- Needed because the walker samples its request only on its slow strobe and ignores requests while busy.

Parameters:
- DEBOUNCE_CYCLES, 120000, consecutive stable cycles required before the debounced level changes (10 ms at 12 MHz); must be >= 2.
- LGDEPTH, 3, width of the pending counter; maximum queued presses is 2^LGDEPTH-1 (7).

Ports:
- i_clk  input  1  system clock; all state on rising edge.
- i_reset_n  input  1  reset, asynchronous assert, active-low.
- i_btn  input  1  raw push-button, asynchronous to i_clk, active-high.
- i_busy  input  1  walker busy flag; high while a walk is in progress.
- o_request  output  1  registered walk request to the walker.
- o_pending  output  LGDEPTH  number of queued presses not yet issued.
- o_overflow  output  1  sticky flag: a press was dropped because the queue was full.

Behaviour:
- Reset (i_reset_n low, async):
  - sync flops, debounced level, debounce counter, press pulse, o_pending, o_overflow and o_request all 0.
  - FSM goes to IDLE; queued presses are discarded, including when reset lands mid-request.
- Synchroniser: two-flop chain on i_btn; nothing else samples i_btn directly.
- Debouncer:
  - counter clears whenever synced level equals debounced level, else increments.
  - when counter reaches DEBOUNCE_CYCLES-1 with the mismatch still present, debounced level takes synced level and counter clears.
  - any glitch shorter than DEBOUNCE_CYCLES produces no change.
  - counter width is clog2(DEBOUNCE_CYCLES); the counter never wraps.
- Press pulse: one-cycle registered pulse on debounced 0->1 transition only; releases generate nothing.
- Pending counter:
  - press only: increment; if already at max, hold and set o_overflow (sticky until reset).
  - take only (FSM IDLE->REQ): decrement.
  - press and take in the same cycle: value unchanged, no overflow, even at max.
  - the counter never underflows; a take occurs only when the count is non-zero.
- FSM, states IDLE, REQ, WAIT_DONE:
  - IDLE: if o_pending != 0 and i_busy == 0, then on the next edge go to REQ, set o_request = 1 and take one from pending. If i_busy is high (walk started elsewhere), stay in IDLE.
  - REQ: hold o_request = 1 until i_busy is seen high, then go to WAIT_DONE with o_request = 0 on that edge. There is no timeout; o_request stays asserted indefinitely.
  - WAIT_DONE: on i_busy == 0, go to IDLE. Back-to-back presses therefore produce exactly one request per completed walk.
- Latency:
  - debounced edge to press pulse: 1 cycle.
  - press to pending increment: 1 cycle.
  - pending non-zero in IDLE to o_request high: 1 cycle.
- o_request asserts only from REQ and is never asserted while i_busy is high at entry.

Test Plan (DEBOUNCE_CYCLES=4, LGDEPTH=3):
- Reset -> all outputs 0. Hold i_btn=1 for 10 cycles, busy low -> one press; o_pending pulses 1 then 0; o_request rises 1 cycle after o_pending=1.
- i_btn bounces 1,0,1,0 at 1-cycle intervals, then stays 1 -> exactly one press counted; a 3-cycle pulse alone -> no press.
- Single press, i_busy held low for 20 cycles after o_request -> o_request stays 1 throughout. Raise i_busy -> o_request 0 next edge. Drop i_busy -> FSM returns to IDLE.
- 3 presses while i_busy=1 from start -> o_pending=3 and no request. Then 3 busy high/low walk cycles -> exactly 3 requests, o_pending 3->2->1->0.
- 9 presses with i_busy stuck high -> o_pending saturates at 7, o_overflow=1. Drop busy -> overflow stays 1.
- Reset asserted in REQ with o_pending=2 -> o_request, o_pending, o_overflow go 0 immediately (async); after release no request issues without a new press.
